ysyx_22041207_fetch_unit: RTL and testbench



---
 rtl/ysyx_22041207_fetch_pkg.sv | 15 +
 rtl/ysyx_22041207_fetch_unit_if.sv | 31 +++
 rtl/ysyx_22041207_fetch_fifo.sv | 55 +++++
 rtl/ysyx_22041207_fetch_unit.sv | 85 ++++++++
 tb/tb_ysyx_22041207_fetch_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041207_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package ysyx_22041207_fetch_pkg;

  localparam int INST_W       = 32;
  localparam int ILEN_BYTES   = 4;
  localparam int DEFAULT_XLEN = 64;

  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [INST_W-1:0]       inst;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_22041207_fetch_unit_if.sv
// Bus bundle between the fetch unit (master) and its environment: imem, EX redirect and decode.
interface ysyx_22041207_fetch_unit_if #(
  parameter int XLEN = 64
);
  import ysyx_22041207_fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_o;
  logic [XLEN-1:0]   pc_o;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_o, pc_o,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_o, pc_o,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ysyx_22041207_fetch_fifo.sv
// Small synchronous FIFO with flush; read data is zero whenever the FIFO is empty.
module ysyx_22041207_fetch_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ysyx_22041207_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited imem requests and
// buffers {pc, inst} pairs for decode; a redirect flushes and drops stale responses.
module ysyx_22041207_fetch_unit
  import ysyx_22041207_fetch_pkg::*;
#(
  parameter int              XLEN            = 64,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC),
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic clk,
  input logic rst,
  ysyx_22041207_fetch_unit_if.master bus
);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = XLEN + INST_W;

  logic [XLEN-1:0]    pc_q;
  logic [OUT_W-1:0]   outstanding_q;
  logic [OUT_W-1:0]   drop_q;
  logic               req_valid, accept, resp_ok, keep_resp, push_out;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [XLEN-1:0]    tag_pc;
  logic [OUT_W-1:0]   tag_count;
  logic               tag_full, tag_empty;

  // Requests still in flight hold a FIFO slot, so the buffer can never overflow.
  assign req_valid = !rst && !bus.redirect_valid
                     && (int'(outstanding_q) < MAX_OUTSTANDING)
                     && (int'(outstanding_q) + int'(fifo_count) < FIFO_DEPTH);
  assign accept    = req_valid && bus.imem_req_ready;
  assign resp_ok   = bus.imem_resp_valid && (outstanding_q != '0);
  assign keep_resp = resp_ok && (drop_q == '0);
  assign push_out  = keep_resp && !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = !fifo_empty;
  assign bus.pc_o           = head[ENTRY_W-1:INST_W];
  assign bus.inst_o         = head[INST_W-1:0];

  ysyx_22041207_fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk(clk), .rst(rst),
    .push(accept), .pop(keep_resp), .flush(bus.redirect_valid),
    .wdata(pc_q), .rdata(tag_pc),
    .count(tag_count), .full(tag_full), .empty(tag_empty)
  );

  ysyx_22041207_fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk(clk), .rst(rst),
    .push(push_out), .pop(bus.inst_ready), .flush(bus.redirect_valid),
    .wdata({tag_pc, bus.imem_resp_data}), .rdata(head),
    .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );

  // On redirect every request still unanswered after this cycle belongs to the old path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_q + OUT_W'(accept) - OUT_W'(resp_ok);
      if (bus.redirect_valid) begin
        pc_q   <= bus.redirect_pc & ~XLEN'(ILEN_BYTES - 1);
        drop_q <= outstanding_q - OUT_W'(resp_ok);
      end else begin
        if (accept) pc_q <= pc_q + XLEN'(ILEN_BYTES);
        if (resp_ok && drop_q != '0) drop_q <= drop_q - 1'b1;
      end
    end
  end

  a_resp_needs_request: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_resp_valid && outstanding_q == '0));
  a_tag_tracks_kept: assert property (@(posedge clk) disable iff (rst)
    !(keep_resp && tag_empty) && !(accept && tag_full)
    && (int'(tag_count) <= int'(outstanding_q)));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_out && fifo_full && !bus.inst_ready));

endmodule

// File: tb/tb_ysyx_22041207_fetch_unit.sv
// Directed bench for the fetch unit: per-cycle vector table plus hand-written corner sequences.
module tb_ysyx_22041207_fetch_unit;
  import ysyx_22041207_fetch_pkg::*;

  localparam logic [63:0] B = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ysyx_22041207_fetch_unit_if #(.XLEN(64)) bus ();

  ysyx_22041207_fetch_unit #(
    .XLEN(64), .RESET_PC(64'h8000_0000), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string             name;
    bit                rst_first;
    logic              rdy;
    logic              rv;
    logic [31:0]       rdata;
    logic              redir;
    logic [63:0]       rpc;
    logic              irdy;
    logic              e_rv;
    logic [63:0]       e_addr;
    logic              e_iv;
    logic [63:0]       e_pc;
    logic [31:0]       e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, bit r, logic rdy, logic rv, logic [31:0] rdata,
                              logic redir, logic [63:0] rpc, logic irdy, logic e_rv,
                              logic [63:0] e_addr, logic e_iv, logic [63:0] e_pc,
                              logic [31:0] e_inst);
    vec_t v;
    v.name = name; v.rst_first = r; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.redir = redir; v.rpc = rpc; v.irdy = irdy; v.e_rv = e_rv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  function automatic logic [INST_W-1:0] memData(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkVal(input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.imem_req_ready  = v.rdy;
    bus.imem_resp_valid = v.rv;
    bus.imem_resp_data  = v.rdata;
    bus.redirect_valid  = v.redir;
    bus.redirect_pc     = v.rpc;
    bus.inst_ready      = v.irdy;
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal({v.name, " req_valid"}, 64'(bus.imem_req_valid), 64'(v.e_rv));
    if (v.e_rv) checkVal({v.name, " req_addr"}, bus.imem_req_addr, v.e_addr);
    checkVal({v.name, " inst_valid"}, 64'(bus.inst_valid), 64'(v.e_iv));
    if (v.e_iv) begin
      checkVal({v.name, " pc_o"}, bus.pc_o, v.e_pc);
      checkVal({v.name, " inst_o"}, 64'(bus.inst_o), 64'(v.e_inst));
    end
  endtask

  task automatic idleInputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b0;
  endtask

  // Leaves the bench at posedge+1 with reset released: the next cycle is cycle 0.
  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkVal("reset req_valid", 64'(bus.imem_req_valid), 64'd0);
    checkVal("reset inst_valid", 64'(bus.inst_valid), 64'd0);
    checkVal("reset pc_o", bus.pc_o, 64'd0);
    checkVal("reset inst_o", 64'(bus.inst_o), 64'd0);
    rst = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name, rst_first, rdy, rv, rdata, redir, rpc, irdy | e_rv, e_addr, e_iv, e_pc, e_inst
    vecs.push_back(mk("s1c0", 1, 1, 0, 0,            0, 0, 1, 1, B,      0, 0, 0));
    vecs.push_back(mk("s1c1", 0, 1, 1, 32'h1111_0000, 0, 0, 1, 1, B+4,    0, 0, 0));
    vecs.push_back(mk("s1c2", 0, 1, 1, 32'h1111_0004, 0, 0, 1, 1, B+8,    1, B,   32'h1111_0000));
    vecs.push_back(mk("s1c3", 0, 1, 1, 32'h1111_0008, 0, 0, 1, 1, B+12,   1, B+4, 32'h1111_0004));
    vecs.push_back(mk("s1c4", 0, 1, 1, 32'h1111_000C, 0, 0, 1, 1, B+16,   1, B+8, 32'h1111_0008));

    vecs.push_back(mk("s2c0", 1, 1, 0, 0,            0, 0, 0, 1, B,      0, 0, 0));
    vecs.push_back(mk("s2c1", 0, 1, 1, 32'h2222_0000, 0, 0, 0, 1, B+4,    0, 0, 0));
    vecs.push_back(mk("s2c2", 0, 1, 1, 32'h2222_0004, 0, 0, 0, 1, B+8,    1, B,   32'h2222_0000));
    vecs.push_back(mk("s2c3", 0, 1, 1, 32'h2222_0008, 0, 0, 0, 1, B+12,   1, B,   32'h2222_0000));
    vecs.push_back(mk("s2c4", 0, 1, 1, 32'h2222_000C, 0, 0, 0, 0, 0,      1, B,   32'h2222_0000));
    vecs.push_back(mk("s2c5", 0, 1, 0, 0,            0, 0, 0, 0, 0,      1, B,   32'h2222_0000));
    vecs.push_back(mk("s2c6", 0, 1, 0, 0,            0, 0, 1, 0, 0,      1, B,   32'h2222_0000));
    vecs.push_back(mk("s2c7", 0, 1, 0, 0,            0, 0, 0, 1, B+16,   1, B+4, 32'h2222_0004));
    vecs.push_back(mk("s2c8", 0, 1, 0, 0,            0, 0, 0, 0, 0,      1, B+4, 32'h2222_0004));
    vecs.push_back(mk("s2c9", 0, 1, 1, 32'h2222_0010, 0, 0, 0, 0, 0,      1, B+4, 32'h2222_0004));
    vecs.push_back(mk("s2c10",0, 1, 0, 0,            0, 0, 0, 0, 0,      1, B+4, 32'h2222_0004));

    vecs.push_back(mk("s3c0", 1, 1, 0, 0,            0, 0, 1, 1, B,      0, 0, 0));
    vecs.push_back(mk("s3c1", 0, 1, 0, 0,            0, 0, 1, 1, B+4,    0, 0, 0));
    vecs.push_back(mk("s3c2", 0, 1, 0, 0,            1, 64'h8000_1002, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s3c3", 0, 1, 1, 32'h3333_0000, 0, 0, 1, 0, 0,      0, 0, 0));
    vecs.push_back(mk("s3c4", 0, 1, 1, 32'h3333_0004, 0, 0, 1, 1, 64'h8000_1000, 0, 0, 0));
    vecs.push_back(mk("s3c5", 0, 0, 1, 32'h3333_1000, 0, 0, 1, 1, 64'h8000_1004, 0, 0, 0));
    vecs.push_back(mk("s3c6", 0, 0, 0, 0,            0, 0, 1, 1, 64'h8000_1004, 1, 64'h8000_1000, 32'h3333_1000));
    vecs.push_back(mk("s3c7", 0, 0, 0, 0,            0, 0, 1, 1, 64'h8000_1004, 0, 0, 0));

    vecs.push_back(mk("s4c0", 1, 1, 0, 0,            0, 0, 1, 1, B,      0, 0, 0));
    vecs.push_back(mk("s4c1", 0, 1, 0, 0,            0, 0, 1, 1, B+4,    0, 0, 0));
    vecs.push_back(mk("s4c2", 0, 1, 1, 32'h4444_0000, 1, 64'h8000_2000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s4c3", 0, 0, 1, 32'h4444_0004, 0, 0, 1, 1, 64'h8000_2000, 0, 0, 0));
    vecs.push_back(mk("s4c4", 0, 1, 0, 0,            0, 0, 1, 1, 64'h8000_2000, 0, 0, 0));
    vecs.push_back(mk("s4c5", 0, 0, 1, 32'h4444_2000, 0, 0, 1, 1, 64'h8000_2004, 0, 0, 0));
    vecs.push_back(mk("s4c6", 0, 0, 0, 0,            0, 0, 1, 1, 64'h8000_2004, 1, 64'h8000_2000, 32'h4444_2000));
    vecs.push_back(mk("s4c7", 0, 0, 0, 0,            0, 0, 1, 1, 64'h8000_2004, 0, 0, 0));

    vecs.push_back(mk("s5c0", 1, 1, 0, 0,            0, 0, 1, 1, B,      0, 0, 0));
    vecs.push_back(mk("s5c1", 0, 1, 0, 0,            0, 0, 1, 1, B+4,    0, 0, 0));
    vecs.push_back(mk("s5c2", 0, 1, 1, 32'h5555_0000, 1, 64'h8000_3000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s5c3", 0, 1, 0, 0,            1, 64'h8000_4004, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s5c4", 0, 0, 1, 32'h5555_0004, 0, 0, 1, 1, 64'h8000_4004, 0, 0, 0));
    vecs.push_back(mk("s5c5", 0, 1, 0, 0,            0, 0, 1, 1, 64'h8000_4004, 0, 0, 0));
    vecs.push_back(mk("s5c6", 0, 0, 1, 32'h5555_4004, 0, 0, 1, 1, 64'h8000_4008, 0, 0, 0));
    vecs.push_back(mk("s5c7", 0, 0, 0, 0,            0, 0, 1, 1, 64'h8000_4008, 1, 64'h8000_4004, 32'h5555_4004));

    vecs.push_back(mk("s6c0", 1, 1, 0, 0,            0, 0, 0, 1, B,      0, 0, 0));
    vecs.push_back(mk("s6c1", 0, 1, 1, 32'h6666_0000, 0, 0, 0, 1, B+4,    0, 0, 0));
    vecs.push_back(mk("s6c2", 0, 0, 1, 32'h6666_0004, 0, 0, 0, 1, B+8,    1, B,   32'h6666_0000));
    vecs.push_back(mk("s6c3", 0, 1, 0, 0,            1, 64'h8000_5000, 1, 0, 0, 1, B, 32'h6666_0000));
    vecs.push_back(mk("s6c4", 0, 1, 0, 0,            0, 0, 1, 1, 64'h8000_5000, 0, 0, 0));
    vecs.push_back(mk("s6c5", 0, 0, 1, 32'h6666_5000, 0, 0, 1, 1, 64'h8000_5004, 0, 0, 0));
    vecs.push_back(mk("s6c6", 0, 0, 0, 0,            0, 0, 1, 1, 64'h8000_5004, 1, 64'h8000_5000, 32'h6666_5000));

    $display("[TB] table: %0d cycle vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) doReset();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i]);
      stepCycle();
    end

    // Ready pattern 1,0,0,1 against a memory that answers three cycles after acceptance.
    begin
      typedef struct { logic [63:0] addr; int due; } pend_t;
      pend_t       pend[$];
      logic [3:0]  pat = 4'b1001;
      logic [63:0] next_issue = B;
      logic [63:0] next_pop = B;
      $display("[TB] ready-toggle sequence");
      doReset();
      for (int c = 0; c < 50; c++) begin
        bus.imem_req_ready = (c < 40) ? pat[3 - (c % 4)] : 1'b0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == c) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = memData(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          bus.imem_resp_valid = 1'b0;
          bus.imem_resp_data  = '0;
        end
        @(negedge clk);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          checkVal("toggle req_addr", bus.imem_req_addr, next_issue);
          pend.push_back('{bus.imem_req_addr, c + 3});
          next_issue = next_issue + 4;
        end
        if (bus.inst_valid) begin
          checkVal("toggle pc_o", bus.pc_o, next_pop);
          checkVal("toggle inst_o", 64'(bus.inst_o), 64'(memData(next_pop)));
          next_pop = next_pop + 4;
        end
        checkVal("toggle outstanding<=2", 64'(pend.size() <= 2), 64'd1);
        stepCycle();
      end
      checkVal("toggle drained", next_pop, next_issue);
      checkVal("toggle progress", 64'(next_issue >= B + 40), 64'd1);
    end

    // Reset asserted asynchronously with work in flight and entries buffered.
    $display("[TB] mid-transfer reset sequence");
    doReset();
    bus.imem_req_ready = 1'b1;
    stepCycle();
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = memData(B);
    stepCycle();
    bus.imem_resp_data = memData(B + 4);
    stepCycle();
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    checkVal("prerst req_valid", 64'(bus.imem_req_valid), 64'd1);
    checkVal("prerst req_addr", bus.imem_req_addr, B + 12);
    checkVal("prerst pc_o", bus.pc_o, B);
    rst = 1'b1;
    #1;
    checkVal("midrst req_valid", 64'(bus.imem_req_valid), 64'd0);
    checkVal("midrst inst_valid", 64'(bus.inst_valid), 64'd0);
    checkVal("midrst pc_o", bus.pc_o, 64'd0);
    checkVal("midrst inst_o", 64'(bus.inst_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    checkVal("postrst req_addr", bus.imem_req_addr, B);
    checkVal("postrst inst_valid", 64'(bus.inst_valid), 64'd0);
    stepCycle();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = memData(B);
    stepCycle();
    bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    checkVal("postrst pc_o", bus.pc_o, B);
    checkVal("postrst inst_o", 64'(bus.inst_o), 64'(memData(B)));
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
